buffer2axis: RTL and testbench
==============================

# buffer2axis

Transmit-side counterpart of the board input path. It accepts one complete WIDTH×HEIGHT board of DWIDTH-bit cells from the conware computation core in a single parallel handshake and holds it in an internal frame buffer. It then streams the buffer out as an AXI4-Stream master, one cell per beat in index order, with TLAST on the final cell. It sits between the compute core and the output DMA/stream fabric.

## Interface
- DWIDTH, 32, bits per cell and per stream beat
- WIDTH, 32, board columns
- HEIGHT, 32, board rows; N = WIDTH*HEIGHT cells per frame, N ≥ 1
- clk  input  1  sole clock, all state updates on rising edge
- rstn  input  1  reset, asynchronous, active-low
- in_data  input  N*DWIDTH  flattened board; cell i at bits [i*DWIDTH +: DWIDTH]
- in_valid  input  1  compute core presents a complete board
- in_ready  output  1  block can accept a board
- M_AXIS_TDATA  output  DWIDTH  current cell
- M_AXIS_TVALID  output  1  beat valid
- M_AXIS_TREADY  input  1  downstream accepts beat
- M_AXIS_TLAST  output  1  final cell of frame
- frames_sent  output  32  count of fully transmitted frames, wraps at 2^32

## Operation
- States: Idle, Send. Registers: state, 32-bit counter, N×DWIDTH frame buffer, frames_sent.
- Reset (rstn low, asynchronous, effective immediately): state=Idle, counter=0, frames_sent=0. Outputs during and after reset: in_ready=1, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=buffer[0]. Buffer contents are not reset and don't-care.
- in_ready = (state==Idle). M_AXIS_TVALID = (state==Send). Both are decoded from the state register only.
- Idle: on in_valid at a rising edge, copy all of in_data into the buffer, set counter=0 and go to Send. Otherwise hold.
- Send: M_AXIS_TDATA = buffer[counter]; M_AXIS_TLAST = (counter==N-1).
  - On TVALID && TREADY with counter<N-1: counter += 1.
  - On TVALID && TREADY with counter==N-1: counter=0, frames_sent += 1, state=Idle.
  - TREADY low: hold counter, TDATA and TLAST.
- in_data and in_valid are ignored in Send. Changes to in_data after capture never affect the frame in flight.
- N=1: the first beat carries TLAST. The frame completes on one accepted beat.
- Reset mid-frame: the frame is abandoned with no TLAST emitted, and frames_sent returns to 0.

## Timing
- Capture edge k (in_valid=1 in Idle). in_ready falls and TVALID rises in the cycle after edge k, with TDATA=cell 0.
- One beat per cycle when TREADY is held high. A frame occupies N consecutive Send cycles.
- Last beat accepted at edge m: TVALID=0 and in_ready=1 in the cycle after m. The earliest next capture is edge m+1, so there is one idle cycle between frames.
- AXIS rules: once TVALID is high it stays high until the handshake. TDATA and TLAST are stable while TVALID && !TREADY. TVALID never depends combinationally on TREADY.
- frames_sent updates on the same edge as the final handshake.

## Test plan
Unless stated, DWIDTH=32, WIDTH=HEIGHT=2 (N=4).
- Reset: hold rstn=0 for 3 cycles, then release. Required: in_ready=1, TVALID=0, TLAST=0, frames_sent=0.
- Streaming frame: capture cells {0x11,0x22,0x33,0x44} with TREADY=1. Required: TDATA 0x11,0x22,0x33,0x44 on 4 consecutive cycles, TLAST only on 0x44, frames_sent=1, in_ready=1 the next cycle.
- Backpressure: drive TREADY pattern 1,0,0,1,0,1,1 across one frame. Required: TDATA and TLAST frozen while TREADY=0, no beat lost or repeated, exactly 4 handshakes.
- Input isolation: change in_data and pulse in_valid during Send. Required: the stream is unchanged, no capture occurs, and in_ready stays 0 until the frame ends.
- Async reset mid-frame: assert rstn low between clock edges after 2 beats. Required: TVALID drops immediately. After release the block is in Idle with counter=0 and frames_sent=0, and the next frame starts at cell 0.
- N=1 and back-to-back: with WIDTH=HEIGHT=1, run 3 captures with in_valid held high. Required: each frame is a single beat with TLAST=1, a one-cycle gap separates frames, and frames_sent=3.

Source files
------------

// File: rtl/buffer2axis.sv
// ============================================================================
// buffer2axis : captures a full board in one handshake, streams it as AXI4-Stream
// Revision 1.0
// ============================================================================
`default_nettype none

module buffer2axis #(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [WIDTH*HEIGHT*DWIDTH-1:0]   in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DWIDTH-1:0]                M_AXIS_TDATA,
    output logic                             M_AXIS_TVALID,
    input  logic                             M_AXIS_TREADY,
    output logic                             M_AXIS_TLAST,
    output logic [31:0]                      frames_sent
);

    localparam int          N        = WIDTH * HEIGHT;
    localparam int          IDXW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [31:0] LAST_IDX = 32'(N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]        state;
    logic [31:0]       counter;
    logic [DWIDTH-1:0] buffer [N];
    logic              capture;
    logic              at_last;

    assign capture = (state == S_IDLE) && in_valid;
    assign at_last = (counter == LAST_IDX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            counter     <= '0;
            frames_sent <= '0;
        end else if (state == S_IDLE) begin
            if (in_valid) begin
                state   <= S_SEND;
                counter <= '0;
            end
        end else if (M_AXIS_TREADY) begin
            if (at_last) begin
                state       <= S_IDLE;
                counter     <= '0;
                frames_sent <= frames_sent + 32'd1;
            end else begin
                counter <= counter + 32'd1;
            end
        end
    end

    // Frame store is data-only; its contents are meaningless until the first capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < N; i++) begin
                buffer[i] <= in_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign in_ready      = (state == S_IDLE);
    assign M_AXIS_TVALID = (state == S_SEND);
    assign M_AXIS_TDATA  = buffer[counter[IDXW-1:0]];
    assign M_AXIS_TLAST  = (state == S_SEND) && at_last;

endmodule

`default_nettype wire

// File: tb/tb_buffer2axis.sv
// ============================================================================
// tb_buffer2axis : scoreboard bench for buffer2axis (N=4 and N=1 instances)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_buffer2axis;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic [127:0] in_data4;
    logic         in_valid4, in_ready4;
    logic [31:0]  tdata4;
    logic         tvalid4, tready4, tlast4;
    logic [31:0]  frames4;

    logic [31:0]  in_data1;
    logic         in_valid1, in_ready1;
    logic [31:0]  tdata1;
    logic         tvalid1, tready1, tlast1;
    logic [31:0]  frames1;

    buffer2axis #(.DWIDTH(32), .WIDTH(2), .HEIGHT(2)) dut4 (
        .clk(clk), .rstn(rstn), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .M_AXIS_TDATA(tdata4), .M_AXIS_TVALID(tvalid4),
        .M_AXIS_TREADY(tready4), .M_AXIS_TLAST(tlast4), .frames_sent(frames4)
    );

    buffer2axis #(.DWIDTH(32), .WIDTH(1), .HEIGHT(1)) dut1 (
        .clk(clk), .rstn(rstn), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .M_AXIS_TDATA(tdata1), .M_AXIS_TVALID(tvalid1),
        .M_AXIS_TREADY(tready1), .M_AXIS_TLAST(tlast1), .frames_sent(frames1)
    );

    int checks = 0;
    int errors = 0;

    // Expected beats as {last, data}; frame counts are completed frames seen.
    logic [32:0] q4[$];
    logic [32:0] q1[$];
    int exp4 = 0, exp1 = 0, hs4 = 0, hs1 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitors: pop the scoreboard on each handshake, police AXIS stability.
    logic        stall4 = 1'b0, stall1 = 1'b0;
    logic [32:0] held4, held1, e4, e1;

    always @(negedge clk) begin
        if (!rstn) begin
            stall4 = 1'b0;
        end else begin
            chk("frames4", 64'(frames4), 64'(exp4));
            if (stall4) begin
                chk("hold_valid4", 64'(tvalid4), 64'd1);
                chk("hold_beat4", 64'({tlast4, tdata4}), 64'(held4));
            end
            stall4 = 1'b0;
            if (tvalid4) begin
                if (tready4) begin
                    if (q4.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat4 actual=%0h required=no_beat", {tlast4, tdata4});
                    end else begin
                        e4 = q4.pop_front();
                        chk("beat4", 64'({tlast4, tdata4}), 64'(e4));
                        hs4++;
                        if (e4[32]) exp4++;
                    end
                end else begin
                    stall4 = 1'b1;
                    held4  = {tlast4, tdata4};
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            stall1 = 1'b0;
        end else begin
            chk("frames1", 64'(frames1), 64'(exp1));
            if (stall1) begin
                chk("hold_valid1", 64'(tvalid1), 64'd1);
                chk("hold_beat1", 64'({tlast1, tdata1}), 64'(held1));
            end
            stall1 = 1'b0;
            if (tvalid1) begin
                if (tready1) begin
                    if (q1.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat1 actual=%0h required=no_beat", {tlast1, tdata1});
                    end else begin
                        e1 = q1.pop_front();
                        chk("beat1", 64'({tlast1, tdata1}), 64'(e1));
                        hs1++;
                        if (e1[32]) exp1++;
                    end
                end else begin
                    stall1 = 1'b1;
                    held1  = {tlast1, tdata1};
                end
            end
        end
    end

    function automatic logic [127:0] rand_frame();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer a frame; the capture edge is the first one where in_ready is seen high.
    task automatic send4(input logic [127:0] d);
        int n = 0;
        in_data4  = d;
        in_valid4 = 1'b1;
        @(negedge clk);
        while (!in_ready4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready4) begin
            checks++; errors++;
            $display("FAIL capture_timeout4 actual=in_ready_low required=in_ready_high");
        end else begin
            for (int i = 0; i < 4; i++) q4.push_back({(i == 3), d[i*32 +: 32]});
        end
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic drain4(input bit rnd);
        int n = 0;
        while (q4.size() != 0 && n < 300) begin
            tready4 = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (q4.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout4 actual=%0d required=0", q4.size());
        end
        tready4 = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        bit           pat [7];
        int           base;
        int           caps;

        rstn = 1'b0;
        in_data4 = '0; in_valid4 = 1'b0; tready4 = 1'b1;
        in_data1 = '0; in_valid1 = 1'b0; tready1 = 1'b1;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready4", 64'(in_ready4), 64'd1);
        chk("rst_tvalid4",   64'(tvalid4),   64'd0);
        chk("rst_tlast4",    64'(tlast4),    64'd0);
        chk("rst_frames4",   64'(frames4),   64'd0);
        chk("rst_in_ready1", 64'(in_ready1), 64'd1);
        chk("rst_tvalid1",   64'(tvalid1),   64'd0);
        chk("rst_tlast1",    64'(tlast1),    64'd0);
        chk("rst_frames1",   64'(frames1),   64'd0);
        #2 rstn = 1'b1;
        @(posedge clk); #1;

        // Streaming frame
        send4({32'h44, 32'h33, 32'h22, 32'h11});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stream_valid", 64'(tvalid4), 64'd1);
            chk("stream_last",  64'(tlast4),  64'(i == 3));
        end
        @(negedge clk);
        chk("stream_ready_after", 64'(in_ready4), 64'd1);
        chk("stream_frames",      64'(frames4),   64'd1);
        @(posedge clk); #1;

        // Backpressure pattern across one frame
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        base = hs4;
        send4(rand_frame());
        for (int i = 0; i < 7; i++) begin
            tready4 = pat[i];
            @(posedge clk); #1;
        end
        tready4 = 1'b1;
        chk("bp_handshakes", 64'(hs4 - base), 64'd4);
        chk("bp_queue_empty", 64'(q4.size()), 64'd0);

        // Random frames under random backpressure
        repeat (6) begin
            send4(rand_frame());
            drain4(1'b1);
        end

        // Input isolation: scribble in_data / in_valid while sending
        send4(rand_frame());
        for (int n = 0; n < 100 && q4.size() != 0; n++) begin
            in_data4  = rand_frame();
            in_valid4 = $urandom_range(0, 1) != 0;
            tready4   = $urandom_range(0, 1) != 0;
            @(negedge clk);
            if (tvalid4) chk("iso_in_ready", 64'(in_ready4), 64'd0);
            @(posedge clk); #1;
        end
        in_valid4 = 1'b0;
        tready4   = 1'b1;
        chk("iso_queue_empty", 64'(q4.size()), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("iso_no_capture", 64'(tvalid4), 64'd0);
        end
        @(posedge clk); #1;

        // Asynchronous reset after two accepted beats
        send4(rand_frame());
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("amid_tvalid", 64'(tvalid4),   64'd0);
        chk("amid_tlast",  64'(tlast4),    64'd0);
        chk("amid_ready",  64'(in_ready4), 64'd1);
        chk("amid_frames", 64'(frames4),   64'd0);
        q4.delete();
        exp4 = 0;
        exp1 = 0;
        @(posedge clk); #2;
        rstn = 1'b1;
        @(negedge clk);
        chk("amid_idle_after", 64'(in_ready4), 64'd1);
        @(posedge clk); #1;
        d = rand_frame();
        send4(d);
        drain4(1'b0);
        chk("amid_next_frames", 64'(exp4), 64'd1);

        // N=1, back-to-back captures with in_valid held high
        tready1   = 1'b1;
        in_data1  = $urandom;
        in_valid1 = 1'b1;
        caps = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("n1_valid_pattern", 64'(tvalid1), 64'(c % 2));
            if (in_ready1 && caps < 3) begin
                q1.push_back({1'b1, in_data1});
                caps++;
            end
            @(posedge clk); #1;
            if (caps == 3) in_valid1 = 1'b0;
            in_data1 = $urandom;
        end
        @(negedge clk);
        chk("n1_idle_end",   64'(tvalid1),    64'd0);
        chk("n1_frames",     64'(frames1),    64'd3);
        chk("n1_queue_empty", 64'(q1.size()), 64'd0);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
